// File: rtl/elastic_rr_merge.sv
// -----------------------------------------------------------------------------
// elastic_rr_merge
//
// Round-robin merge of NUM_INPUT elastic (valid/stop) producers onto a single
// elastic consumer channel. The output is a one-entry register stage. A token
// accepted in cycle N is presented on the output in cycle N+1. The stage
// sustains one token per cycle because a draining output can be refilled on
// the same edge.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous, active-high; clears the output stage and the
//                  round-robin pointer, and holds every stop_input high
//   data_input     per-requester token data (unpacked array)
//   valid_input    per-requester valid
//   stop_input     per-requester backpressure; low only for the granted input
//   data_output    merged token data (registered)
//   valid_output   merged token valid (registered)
//   source_output  index of the requester that produced the current token
//   stop_output    backpressure from the consumer
// -----------------------------------------------------------------------------
module elastic_rr_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUT  = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_input [NUM_INPUT],
  input  logic [NUM_INPUT-1:0]  valid_input,
  output logic [NUM_INPUT-1:0]  stop_input,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic                  valid_output,
  output logic [SEL_WIDTH-1:0]  source_output,
  input  logic                  stop_output
);

  if (NUM_INPUT < 2 || NUM_INPUT > 16) begin : g_bad_num_input
    $error("elastic_rr_merge: NUM_INPUT must be in 2..16");
  end
  if (SEL_WIDTH != $clog2(NUM_INPUT)) begin : g_bad_sel_width
    $error("elastic_rr_merge: SEL_WIDTH must equal $clog2(NUM_INPUT)");
  end

  // One extra bit so ptr + offset (at most 2*NUM_INPUT-2) cannot overflow
  // before the modulo fold.
  localparam logic [SEL_WIDTH:0]   NUM_W    = (SEL_WIDTH + 1)'(NUM_INPUT);
  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_INPUT - 1);

  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] grant_idx;
  logic                 grant_vld;
  logic                 load_en;

  // The output register can take a new token when it is empty or when its
  // current token leaves on this edge.
  assign load_en = !valid_output || !stop_output;

  // Scan offsets from the farthest to the nearest, so the requester closest
  // to ptr (in rotation order) is the last writer and wins. This avoids a
  // separate "already found" flag in the loop.
  always_comb begin
    logic [SEL_WIDTH:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NUM_INPUT - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (SEL_WIDTH + 1)'(k);
      if (cand >= NUM_W) begin
        cand = cand - NUM_W;
      end
      if (valid_input[cand[SEL_WIDTH-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[SEL_WIDTH-1:0];
      end
    end
  end

  // Only the granted requester sees stop low. Reset forces every stop high
  // so no producer believes a token was taken while the stage is cleared.
  always_comb begin
    stop_input = '1;
    for (int i = 0; i < NUM_INPUT; i++) begin
      stop_input[i] = reset ||
                      !(load_en && grant_vld && (grant_idx == SEL_WIDTH'(i)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_output  <= 1'b0;
      data_output   <= '0;
      source_output <= '0;
      ptr           <= '0;
    end else if (load_en) begin
      if (grant_vld) begin
        valid_output  <= 1'b1;
        data_output   <= data_input[grant_idx];
        source_output <= grant_idx;
        // Explicit wrap keeps ptr below NUM_INPUT for non-power-of-2 sizes.
        ptr           <= (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_WIDTH'(1);
      end else begin
        valid_output  <= 1'b0;
      end
    end
  end

endmodule
